// File: rtl/lc3_pkg.sv
// lc3_pkg -- shared types and constants for the LC-3 style branch controller.
//   opcode_e         : 4-bit instruction opcode (IR[15:12])
//   state_e          : controller FSM states
//   PC_RESET_DEFAULT : default program counter value after reset
//   sets_cc()        : true for opcodes that write a result and update N/Z/P
package lc3_pkg;

    typedef enum logic [3:0] {
        OP_BR   = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_LD   = 4'b0010,
        OP_ST   = 4'b0011,
        OP_JSR  = 4'b0100,
        OP_AND  = 4'b0101,
        OP_LDR  = 4'b0110,
        OP_STR  = 4'b0111,
        OP_RTI  = 4'b1000,
        OP_NOT  = 4'b1001,
        OP_LDI  = 4'b1010,
        OP_STI  = 4'b1011,
        OP_JMP  = 4'b1100,
        OP_RES  = 4'b1101,
        OP_LEA  = 4'b1110,
        OP_TRAP = 4'b1111
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_WAIT_RES,
        S_EVAL,
        S_FINISH
    } state_e;

    localparam logic [15:0] PC_RESET_DEFAULT = 16'h0000;

    function automatic logic sets_cc(input opcode_e op);
        case (op)
            OP_ADD, OP_AND, OP_NOT, OP_LD, OP_LDR, OP_LDI, OP_LEA: sets_cc = 1'b1;
            default:                                               sets_cc = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pc_next.sv
// pc_next -- combinational next-PC computation.
//   pc_i      : current program counter
//   offset_i  : 9-bit signed PC offset (IR[8:0])
//   taken_i   : 1 = add the sign-extended offset, 0 = sequential increment
//   pc_next_o : pc_i + 1 (+ sext(offset_i) when taken), modulo 2^16
module pc_next
    import lc3_pkg::*;
(
    input  logic [15:0] pc_i,
    input  logic [8:0]  offset_i,
    input  logic        taken_i,
    output logic [15:0] pc_next_o
);

    logic [15:0] offset_sext;

    assign offset_sext = {{7{offset_i[8]}}, offset_i};
    // 16-bit addition wraps naturally; no overflow indication is wanted.
    assign pc_next_o   = pc_i + 16'd1 + (taken_i ? offset_sext : 16'd0);

endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl -- sequencing FSM for one instruction: decode, optional wait for
// a CC-setting result, optional branch evaluation, then PC update.
//   Clk         : clock, rising edge
//   Reset       : synchronous, active-low
//   Start       : accept the instruction on IR (IDLE only)
//   Abort       : cancel a pending result wait (WAIT_RES only)
//   IR          : instruction word, captured on accepted Start
//   ResultValid : datapath result for a CC-setting op is on the bus
//   BEN         : registered branch enable from the NZP block
//   LDCC        : load strobe for the N/Z/P registers
//   LDBEN       : load strobe for the branch-enable register
//   PC          : program counter (registered)
//   Taken       : last branch taken; held until the next accepted Start
//   Done        : one-cycle completion pulse
module branch_ctrl
    import lc3_pkg::*;
#(
    parameter logic [15:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Abort,
    input  logic [15:0] IR,
    input  logic        ResultValid,
    input  logic        BEN,
    output logic        LDCC,
    output logic        LDBEN,
    output logic [15:0] PC,
    output logic        Taken,
    output logic        Done
);

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic        taken_q, taken_d;
    logic [15:0] pc_calc;
    logic        ldcc_raw, ldben_raw, done_raw;
    opcode_e     opcode;

    // The NZP field of a BR is consumed by the condition block, not here.
    logic        unused_nzp;
    assign unused_nzp = ^ir_q[11:9];

    assign opcode = opcode_e'(ir_q[15:12]);

    pc_next u_pc_next (
        .pc_i      (pc_q),
        .offset_i  (ir_q[8:0]),
        .taken_i   (taken_q),
        .pc_next_o (pc_calc)
    );

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        taken_d   = taken_q;
        pc_d      = pc_q;
        ldcc_raw  = 1'b0;
        ldben_raw = 1'b0;
        done_raw  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    ir_d    = IR;
                    taken_d = 1'b0;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ldben_raw = 1'b1;
                if (opcode == OP_BR) begin
                    state_d = S_EVAL;
                end else if (sets_cc(opcode)) begin
                    state_d = S_WAIT_RES;
                end else begin
                    state_d = S_FINISH;
                end
            end
            S_WAIT_RES: begin
                // Abort wins over a simultaneous ResultValid.
                if (Abort) begin
                    state_d = S_IDLE;
                end else if (ResultValid) begin
                    ldcc_raw = 1'b1;
                    state_d  = S_FINISH;
                end
            end
            S_EVAL: begin
                // BEN is valid here: it was loaded on the LDBEN edge one cycle ago.
                taken_d = BEN;
                state_d = S_FINISH;
            end
            S_FINISH: begin
                done_raw = 1'b1;
                pc_d     = pc_calc;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            pc_q    <= PC_RESET;
            ir_q    <= 16'h0000;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            taken_q <= taken_d;
        end
    end

    // Strobes are forced low while reset is held, even if the state register
    // still shows a mid-operation state before the reset edge.
    assign LDCC  = ldcc_raw  & Reset;
    assign LDBEN = ldben_raw & Reset;
    assign Done  = done_raw  & Reset;
    assign PC    = pc_q;
    assign Taken = taken_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl -- directed scenarios plus randomized traffic for branch_ctrl,
// checked every cycle against a transaction-level model of the controller.
module tb_branch_ctrl;

    logic        Clk = 1'b0;
    logic        Reset, Start, Abort, ResultValid, BEN;
    logic [15:0] IR;

    logic        ldcc0, ldben0, taken0, done0;
    logic [15:0] pc0;
    logic        ldcc1, ldben1, taken1, done1;
    logic [15:0] pc1;

    int checks   = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    branch_ctrl dut0 (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Abort(Abort), .IR(IR),
        .ResultValid(ResultValid), .BEN(BEN), .LDCC(ldcc0), .LDBEN(ldben0),
        .PC(pc0), .Taken(taken0), .Done(done0)
    );

    branch_ctrl #(.PC_RESET(16'h3000)) dut1 (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Abort(Abort), .IR(IR),
        .ResultValid(ResultValid), .BEN(BEN), .LDCC(ldcc1), .LDBEN(ldben1),
        .PC(pc1), .Taken(taken1), .Done(done1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // An accepted instruction is tracked by its kind and the number of cycles
    // since the Start cycle; outputs follow from the documented latencies.
    localparam int K_OTHER = 0, K_BR = 1, K_CC = 2;

    bit          m_valid = 1'b0;
    bit          m_busy  = 1'b0;
    int          m_cyc   = 0;
    int          m_kind  = 0;
    bit          m_rv_seen = 1'b0;
    bit          m_fin;
    bit          m_taken = 1'b0;
    logic [15:0] m_pc    = 16'h0000;
    logic [15:0] m_ir    = 16'h0000;
    int          m_off;

    function automatic int kind_of(input logic [3:0] op);
        if (op == 4'h0) return K_BR;
        if (op inside {4'h1, 4'h5, 4'h9, 4'h2, 4'h6, 4'hA, 4'hE}) return K_CC;
        return K_OTHER;
    endfunction

    always @(posedge Clk) begin
        if (!Reset) begin
            m_valid = 1'b1;
            m_busy  = 1'b0;
            m_pc    = 16'h0000;
            m_taken = 1'b0;
            m_ir    = 16'h0000;
        end else if (!m_busy) begin
            if (Start) begin
                m_busy    = 1'b1;
                m_cyc     = 1;
                m_ir      = IR;
                m_taken   = 1'b0;
                m_kind    = kind_of(IR[15:12]);
                m_rv_seen = 1'b0;
            end
        end else begin
            m_fin = 1'b0;
            case (m_kind)
                K_BR: begin
                    if (m_cyc == 2) m_taken = BEN;
                    if (m_cyc == 3) m_fin = 1'b1;
                end
                K_CC: begin
                    if (m_rv_seen) m_fin = 1'b1;
                    else if (m_cyc >= 2) begin
                        if (Abort) m_busy = 1'b0;
                        else if (ResultValid) m_rv_seen = 1'b1;
                    end
                end
                default: if (m_cyc == 2) m_fin = 1'b1;
            endcase
            if (m_fin) begin
                m_off  = m_ir[8] ? int'(m_ir[8:0]) - 512 : int'(m_ir[8:0]);
                m_pc   = 16'(int'(m_pc) + 1 + (m_taken ? m_off : 0));
                m_busy = 1'b0;
            end
            m_cyc++;
        end
    end

    // Compare DUT0 against the model on every falling edge.
    bit exp_ldben, exp_ldcc, exp_done;
    always @(negedge Clk) begin
        if (m_valid) begin
            exp_ldben = Reset && m_busy && m_cyc == 1;
            exp_done  = Reset && m_busy &&
                        ((m_kind == K_OTHER && m_cyc == 2) ||
                         (m_kind == K_BR    && m_cyc == 3) ||
                         (m_kind == K_CC    && m_rv_seen));
            exp_ldcc  = Reset && m_busy && m_kind == K_CC && m_cyc >= 2 && !m_rv_seen &&
                        ResultValid && !Abort;
            check("model_LDBEN", ldben0, exp_ldben);
            check("model_LDCC",  ldcc0,  exp_ldcc);
            check("model_Done",  done0,  exp_done);
            check("model_PC",    pc0,    m_pc);
            check("model_Taken", taken0, m_taken);
            check("ldcc_ldben_exclusive", ldcc0 & ldben0, 1'b0);
        end
    end

    // ---------------- directed stimulus helpers ----------------
    logic        o_done, o_ldcc, o_ldben, o1_done, o1_ldben;

    task automatic step(input bit st, input logic [15:0] ir, input bit rv,
                        input bit ab, input bit ben, input bit rst_n);
        Start = st; IR = ir; ResultValid = rv; Abort = ab; BEN = ben; Reset = rst_n;
        @(negedge Clk);
        o_done = done0; o_ldcc = ldcc0; o_ldben = ldben0;
        o1_done = done1; o1_ldben = ldben1;
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_br(input logic [15:0] ir, input bit ben);
        step(1'b1, ir, 1'b0, 1'b0, ben, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 1'b0, 1'b0, ben, 1'b1);
        check("br_done_cycle3", o_done, 1'b1);
    endtask

    int n_ldcc, n_done;

    initial begin
        Reset = 1'b0; Start = 1'b0; Abort = 1'b0; ResultValid = 1'b0; BEN = 1'b0; IR = 16'h0;

        // Reset values
        do_reset();
        do_reset();
        check("rst_pc0",    pc0, 16'h0000);
        check("rst_pc1",    pc1, 16'h3000);
        check("rst_taken",  taken0, 1'b0);
        check("rst_done",   done0, 1'b0);
        check("rst_ldcc",   ldcc0, 1'b0);
        check("rst_ldben",  ldben0, 1'b0);

        // Reset in the middle of a CC wait, with ResultValid high
        step(1'b1, 16'h1261, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        check("midrst_ldcc_gated", o_ldcc, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        check("midrst_no_done", o_done, 1'b0);
        check("midrst_pc", pc0, 16'h0000);

        // Reset in FINISH of a taken branch: no PC update, Taken cleared
        step(1'b1, 16'h0A05, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
        check("finrst_taken_before", taken0, 1'b1);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        check("finrst_done_gated", o_done, 1'b0);
        check("finrst_pc", pc0, 16'h0000);
        check("finrst_taken", taken0, 1'b0);

        // Taken branch from PC=0x3000, IR=0x0A05, BEN=1
        do_reset();
        step(1'b1, 16'h0A05, 1'b0, 1'b0, 1'b1, 1'b1);
        check("br_c0_ldben", o1_ldben, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
        check("br_c1_ldben", o1_ldben, 1'b1);
        check("br_c1_done", o1_done, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
        check("br_c2_ldben", o1_ldben, 1'b0);
        check("br_c2_done", o1_done, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
        check("br_c3_done", o1_done, 1'b1);
        check("br_pc1", pc1, 16'h3006);
        check("br_taken1", taken1, 1'b1);
        check("br_pc0", pc0, 16'h0006);
        check("model_pin_br_pc", m_pc, 16'h0006);
        check("model_pin_br_taken", m_taken, 1'b1);

        // Wrap-around at 0xFFFF
        do_reset();
        run_br(16'h0FFE, 1'b1);
        check("wrap_to_ffff", pc0, 16'hFFFF);
        check("model_pin_ffff", m_pc, 16'hFFFF);
        run_br(16'h0E01, 1'b1);
        check("wrap_taken_pc", pc0, 16'h0001);
        check("wrap_taken", taken0, 1'b1);
        run_br(16'h0FFD, 1'b1);
        check("wrap_back_ffff", pc0, 16'hFFFF);
        run_br(16'h0E01, 1'b0);
        check("wrap_nt_pc", pc0, 16'h0000);
        check("wrap_nt_taken", taken0, 1'b0);

        // CC op with ResultValid low for three wait cycles
        do_reset();
        n_ldcc = 0;
        step(1'b1, 16'h1261, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        check("cc_c1_ldben", o_ldben, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
            n_ldcc += int'(o_ldcc);
            check("cc_wait_no_done", o_done, 1'b0);
        end
        step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        check("cc_ldcc_in_rv_cycle", o_ldcc, 1'b1);
        n_ldcc += int'(o_ldcc);
        step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        check("cc_done_next", o_done, 1'b1);
        n_ldcc += int'(o_ldcc);
        check("cc_single_ldcc", n_ldcc, 1);
        check("cc_pc", pc0, 16'h0001);

        // Abort together with ResultValid in WAIT_RES
        do_reset();
        step(1'b1, 16'h2005, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);
        check("abort_no_ldcc", o_ldcc, 1'b0);
        n_done = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
            n_done += int'(o_done) + int'(o_ldcc);
        end
        check("abort_quiet", n_done, 0);
        check("abort_pc", pc0, 16'h0000);
        step(1'b1, 16'hC1C0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        check("abort_back_idle", o_ldben, 1'b1);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);

        // Back-to-back with Start held high
        do_reset();
        n_done = 0; n_ldcc = 0;
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 16'hC1C0, 1'b0, 1'b0, 1'b0, 1'b1);
            check("b2b_done_pattern", o_done, (i % 3) == 2);
            n_done += int'(o_done);
            n_ldcc += int'(o_ldcc);
        end
        check("b2b_done_count", n_done, 3);
        check("b2b_no_ldcc", n_ldcc, 0);
        check("b2b_pc", pc0, 16'h0003);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);

        // Randomized traffic, biased toward BR and CC-setting opcodes
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] r_ir;
            r_ir = 16'($urandom);
            if ($urandom_range(0, 2) == 0) r_ir[15:12] = 4'h0;
            step($urandom_range(0, 2) == 0, r_ir, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0, 1'($urandom), $urandom_range(0, 149) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 SHALL have parameter PC_RESET, default 16'h0000: PC value loaded on reset.
REQ-002 SHALL have port Clk  input  1: single clock, all state updates on the rising edge.
REQ-003 SHALL have port Reset  input  1: synchronous, active-low reset.
REQ-004 SHALL have port Start  input  1: begin processing the instruction on IR; sampled only in IDLE.
REQ-005 SHALL have port Abort  input  1: cancel a pending result wait; honoured only in WAIT_RES.
REQ-006 SHALL have port IR  input  16: instruction word; captured into an internal IR_q register on accepted Start.
REQ-007 SHALL have port ResultValid  input  1: the datapath result for a CC-setting op is present on the bus.
REQ-008 SHALL have port BEN  input  1: registered branch-enable from the NZP condition block.
REQ-009 SHALL have port LDCC  output  1: load strobe to the N/Z/P registers.
REQ-010 SHALL have port LDBEN  output  1: load strobe to the branch-enable register.
REQ-011 SHALL have port PC  output  16: current program counter (registered).
REQ-012 SHALL have port Taken  output  1: the last branch was taken; held until the next accepted Start.
REQ-013 SHALL have port Done  output  1: one-cycle completion pulse.

Function
REQ-014 SHALL implement the states IDLE, DECODE, WAIT_RES, EVAL and FINISH.
REQ-015 IDLE SHALL go to DECODE on Start=1, capturing IR into IR_q and clearing Taken; Start is ignored in all other states.
REQ-016 DECODE SHALL last exactly one cycle and SHALL drive LDBEN=1 for that cycle only.
REQ-017 DECODE SHALL go to EVAL when IR_q[15:12]=0000 (BR).
REQ-018 DECODE SHALL go to WAIT_RES for the CC-setting opcodes ADD 0001, AND 0101, NOT 1001, LD 0010, LDR 0110, LDI 1010 and LEA 1110.
REQ-019 DECODE SHALL go to FINISH for all other opcodes.
REQ-020 In WAIT_RES, LDCC SHALL equal ResultValid combinationally (Abort=0), so LDCC is high for exactly the first cycle in which ResultValid=1, after which the FSM goes to FINISH.
REQ-021 In WAIT_RES, Abort=1 SHALL return the FSM to IDLE with no LDCC, no Done and no PC change; Abort has priority over a simultaneous ResultValid.
REQ-022 ResultValid and Abort SHALL be ignored outside WAIT_RES.
REQ-023 EVAL SHALL last one cycle, sample BEN (valid one cycle after LDBEN), latch Taken=BEN and go to FINISH.
REQ-024 FINISH SHALL drive Done=1 for one cycle, return to IDLE, and update PC on that edge.
REQ-025 The PC update SHALL be PC+1+sext(IR_q[8:0]) when Taken=1, else PC+1, all modulo 2^16 (wrap-around, no flag).
REQ-026 Latency from the Start cycle to the Done cycle SHALL be 2 cycles for non-CC ops, 3 cycles for BR, and 2+N cycles for CC ops, where N is the number of WAIT_RES cycles.
REQ-027 A Start held high SHALL be accepted again only in the cycle after Done, when the FSM is back in IDLE.
REQ-028 LDCC and LDBEN SHALL never be asserted in the same cycle.

Reset
REQ-029 A clock edge with Reset=0 SHALL force, from any state including mid-operation: state=IDLE, PC=PC_RESET, IR_q=0 and Taken=0.
REQ-030 During Reset=0, Done, LDCC and LDBEN SHALL be 0.

Structure
REQ-031 Package lc3_pkg SHALL hold the opcode enum (4-bit), the state enum and the constant PC_RESET_DEFAULT.
REQ-032 Sub-module pc_next SHALL compute the next PC from PC, the 9-bit offset and Taken, combinationally.
REQ-033 All other logic SHALL be in branch_ctrl.

Verification
REQ-034 Reset: hold Reset=0 for 1 cycle from any state -> PC=0x0000; Done, LDCC, LDBEN and Taken all 0; FSM in IDLE.
REQ-035 Taken branch: PC=0x3000, IR=0x0A05, BEN=1 -> LDBEN in cycle 1, Done in cycle 3, Taken=1, PC=0x3006.
REQ-036 Wrap-around: PC=0xFFFF, IR=0x0E01, BEN=1 -> PC=0x0001; repeat with BEN=0 -> PC=0x0000 and Taken=0.
REQ-037 CC op: IR=0x1261, ResultValid low for 3 cycles then high -> single LDCC pulse in the ResultValid cycle, Done the next cycle, PC+1.
REQ-038 Abort: IR=0x2005 in WAIT_RES, Abort=1 together with ResultValid=1 -> IDLE, no LDCC, no Done, PC unchanged.
REQ-039 Back-to-back: Start held high with IR=0xC1C0 -> Done every 3rd cycle, PC increments by 1 each time, LDCC never asserted.
